// File: rtl/perm_round_controller_pkg.sv
// perm_round_controller_pkg: shared state encoding, stage codes and size defaults
package perm_round_controller_pkg;
  localparam int NUM_LANES_DEF  = 25;
  localparam int NUM_ROUNDS_DEF = 24;
  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LOAD   = 3'd1;
  localparam logic [2:0] S_THETA  = 3'd2;
  localparam logic [2:0] S_RHO_PI = 3'd3;
  localparam logic [2:0] S_CHI    = 3'd4;
  localparam logic [2:0] S_IOTA   = 3'd5;
  localparam logic [2:0] S_UNLOAD = 3'd6;
  localparam logic [2:0] S_DONE   = 3'd7;
  localparam logic [1:0] STAGE_THETA  = 2'd0;
  localparam logic [1:0] STAGE_RHO_PI = 2'd1;
  localparam logic [1:0] STAGE_CHI    = 2'd2;
  localparam logic [1:0] STAGE_IOTA   = 2'd3;
endpackage

// File: rtl/perm_round_controller_counter.sv
// perm_round_controller_counter: loadable up-counter; load has priority over increment
module perm_round_controller_counter #(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en_i,
  input  logic         load_en_i,
  input  logic [W-1:0] init_count_i,
  output logic [W-1:0] count_o
);
  logic [W-1:0] count_q;
  // load wins so a wrap on the terminal beat never increments past it
  always_ff @(posedge clk or posedge rst)
    if (rst) count_q <= '0;
    else if (load_en_i) count_q <= init_count_i;
    else if (en_i) count_q <= count_q + 1'b1;
  assign count_o = count_q;
endmodule

// File: rtl/perm_round_controller.sv
// perm_round_controller: sequences load, per-round transform stages and unload of the permutation state
module perm_round_controller
  import perm_round_controller_pkg::*;
#(
  parameter int NUM_LANES  = NUM_LANES_DEF,
  parameter int LANE_W     = 5,
  parameter int NUM_ROUNDS = NUM_ROUNDS_DEF,
  parameter int ROUND_W    = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  output logic               busy,
  input  logic               in_valid,
  output logic               in_ready,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [LANE_W-1:0]  lane_addr,
  output logic [ROUND_W-1:0] round_idx,
  output logic [1:0]         stage_sel,
  output logic               mem_we,
  output logic               done
);
  logic [2:0] state_q, state_d;
  logic lane_last, round_last, xform, iota, go, lane_step;
  assign lane_last  = lane_addr == LANE_W'(NUM_LANES - 1);
  assign round_last = round_idx == ROUND_W'(NUM_ROUNDS - 1);
  assign xform      = state_q == S_THETA || state_q == S_RHO_PI || state_q == S_CHI;
  assign iota       = state_q == S_IOTA;
  assign go         = state_q == S_IDLE && start;
  assign lane_step  = xform || (state_q == S_LOAD && in_valid) || (state_q == S_UNLOAD && out_ready);
  perm_round_controller_counter #(.W(LANE_W)) u_lane (
    .clk(clk), .rst(rst), .en_i(lane_step), .load_en_i(go || (lane_step && lane_last)),
    .init_count_i('0), .count_o(lane_addr)
  );
  perm_round_controller_counter #(.W(ROUND_W)) u_round (
    .clk(clk), .rst(rst), .en_i(iota), .load_en_i(go || (iota && round_last)),
    .init_count_i('0), .count_o(round_idx)
  );
  // next state: lane sweeps end on the terminal compare, IOTA closes each round
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   state_d = start ? S_LOAD : S_IDLE;
      S_LOAD:   state_d = (in_valid && lane_last) ? S_THETA : S_LOAD;
      S_THETA:  state_d = lane_last ? S_RHO_PI : S_THETA;
      S_RHO_PI: state_d = lane_last ? S_CHI : S_RHO_PI;
      S_CHI:    state_d = lane_last ? S_IOTA : S_CHI;
      S_IOTA:   state_d = round_last ? S_UNLOAD : S_THETA;
      S_UNLOAD: state_d = (out_ready && lane_last) ? S_DONE : S_UNLOAD;
      default:  state_d = S_IDLE;
    endcase
  end
  // state register
  always_ff @(posedge clk or posedge rst)
    if (rst) state_q <= S_IDLE;
    else state_q <= state_d;
  assign busy      = state_q != S_IDLE;
  assign in_ready  = state_q == S_LOAD;
  assign out_valid = state_q == S_UNLOAD;
  assign done      = state_q == S_DONE;
  assign mem_we    = (state_q == S_LOAD && in_valid) || xform || iota;
  assign stage_sel = state_q == S_THETA  ? STAGE_THETA  :
                     state_q == S_RHO_PI ? STAGE_RHO_PI :
                     state_q == S_CHI    ? STAGE_CHI    :
                     iota                ? STAGE_IOTA   : STAGE_THETA;
endmodule

// File: tb/tb_perm_round_controller.sv
// tb_perm_round_controller: drives permutations with stalls and checks against a slot-list reference model
module tb_perm_round_controller;
  localparam int NL = 25;
  localparam int NR = 24;
  localparam int LAT = 1 + NL + NR * (3 * NL + 1) + NL + 1;
  localparam int K_LOAD = 0, K_XF = 1, K_IOTA = 2, K_UNLOAD = 3, K_DONE = 4;
  logic clk = 1'b0;
  logic rst, start, in_valid, out_ready;
  logic busy, in_ready, out_valid, mem_we, done;
  logic [4:0] lane_addr, round_idx;
  logic [1:0] stage_sel;
  int total = 0;
  int bad = 0;
  typedef struct {int kind; int lane; int rnd; int stage;} slot_t;
  slot_t q[$];

  perm_round_controller dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .in_valid(in_valid), .in_ready(in_ready),
    .out_valid(out_valid), .out_ready(out_ready), .lane_addr(lane_addr), .round_idx(round_idx),
    .stage_sel(stage_sel), .mem_we(mem_we), .done(done)
  );

  always #5 clk = ~clk;

  // expected per-cycle work items of one permutation, in order
  task automatic build();
    q.delete();
    for (int l = 0; l < NL; l++) q.push_back('{K_LOAD, l, 0, 0});
    for (int r = 0; r < NR; r++) begin
      for (int s = 0; s < 3; s++)
        for (int l = 0; l < NL; l++) q.push_back('{K_XF, l, r, s});
      q.push_back('{K_IOTA, 0, r, 3});
    end
    for (int l = 0; l < NL; l++) q.push_back('{K_UNLOAD, l, 0, 0});
    q.push_back('{K_DONE, 0, 0, 0});
  endtask

  task automatic do_reset();
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
  endtask

  // mode: 0 clean, 1 load stall at lane 7, 2 toggled out_ready, 3 random, 4 start spam, 5 reset in round 10
  task automatic run_perm(input int mode, output int lat, output int wr, output int rd, output int hi);
    slot_t s;
    int cyc, stall, guard;
    logic tog, xf;
    logic [16:0] obs, exp;
    build();
    lat = 0; wr = 0; rd = 0; hi = 0; stall = 0; tog = 1'b0; guard = 0;
    @(negedge clk);
    start = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    #1;
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL start_idle busy=%b want=0", busy); end
    @(posedge clk);
    cyc = 1;
    while (q.size() > 0 && guard < 6000) begin
      guard++;
      cyc++;
      s = q[0];
      @(negedge clk);
      if (mode == 1 && s.kind == K_LOAD && s.lane == 7 && stall < 3) begin
        in_valid = 1'b0;
        stall++;
      end else in_valid = (mode == 3) ? ($urandom_range(0, 3) != 0) : 1'b1;
      if (s.kind == K_UNLOAD) tog = ~tog;
      out_ready = (mode == 2) ? ~tog : (mode == 3) ? ($urandom_range(0, 2) != 0) : 1'b1;
      start = (mode == 4) && ((s.kind == K_XF && s.rnd == 5 && s.stage == 2) || s.kind == K_DONE ||
                              $urandom_range(0, 7) == 0);
      if (mode == 5 && s.kind == K_XF && s.rnd == 10 && s.stage == 1 && s.lane == 12) begin
        #1 rst = 1'b1;
        #1;
        total++;
        if ({busy, in_ready, out_valid, mem_we, done, lane_addr, round_idx, stage_sel} !== 17'd0) begin
          bad++;
          $display("FAIL mid_reset outputs=%h want=0",
                   {busy, in_ready, out_valid, mem_we, done, lane_addr, round_idx, stage_sel});
        end
        #1 rst = 1'b0;
        start = 1'b0;
        lat = -2;
        q.delete();
        return;
      end
      #1;
      xf = s.kind == K_XF || s.kind == K_IOTA;
      exp = {1'b1, s.kind == K_LOAD, s.kind == K_UNLOAD, s.kind == K_LOAD ? in_valid : xf,
             s.kind == K_DONE, 5'(s.lane), 5'(s.rnd), xf ? 2'(s.stage) : 2'd0};
      obs = {busy, in_ready, out_valid, mem_we, done, lane_addr, round_idx, xf ? stage_sel : 2'd0};
      total++;
      if (obs !== exp) begin
        bad++;
        $display("FAIL seq mode=%0d cyc=%0d kind=%0d lane=%0d rnd=%0d got=%h want=%h",
                 mode, cyc, s.kind, s.lane, s.rnd, obs, exp);
        lat = -1;
        return;
      end
      if (s.kind == K_DONE) lat = cyc;
      if (in_ready && in_valid && mem_we) wr++;
      if (out_valid && out_ready) rd++;
      if (int'(lane_addr) > hi) hi = int'(lane_addr);
      @(posedge clk);
      if (!((s.kind == K_LOAD && !in_valid) || (s.kind == K_UNLOAD && !out_ready))) void'(q.pop_front());
    end
    if (q.size() > 0) begin
      total++; bad++;
      $display("FAIL timeout mode=%0d slots_left=%0d want=0", mode, q.size());
      return;
    end
    @(negedge clk);
    #1;
    total++;
    if ({busy, done} !== 2'b00) begin bad++; $display("FAIL post_done busy/done=%b want=00", {busy, done}); end
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    #12;
    total++;
    if ({busy, in_ready, out_valid, mem_we, done, lane_addr, round_idx, stage_sel} !== 17'd0) begin
      bad++;
      $display("FAIL reset outputs=%h want=0",
               {busy, in_ready, out_valid, mem_we, done, lane_addr, round_idx, stage_sel});
    end
    do_reset();
    #1;
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL reset_idle busy=%b want=0", busy); end
  endtask

  task automatic test_nominal();
    int lat, wr, rd, hi;
    do_reset();
    run_perm(0, lat, wr, rd, hi);
    total++;
    if (lat !== LAT) begin bad++; $display("FAIL nominal_latency got=%0d want=%0d", lat, LAT); end
    total++;
    if (wr !== NL || rd !== NL) begin bad++; $display("FAIL nominal_beats wr=%0d rd=%0d want=%0d", wr, rd, NL); end
    total++;
    if (hi > NL - 1) begin bad++; $display("FAIL lane_range max=%0d want<=%0d", hi, NL - 1); end
  endtask

  task automatic test_load_stall();
    int lat, wr, rd, hi;
    do_reset();
    run_perm(1, lat, wr, rd, hi);
    total++;
    if (lat !== LAT + 3) begin bad++; $display("FAIL load_stall_latency got=%0d want=%0d", lat, LAT + 3); end
    total++;
    if (wr !== NL) begin bad++; $display("FAIL load_stall_writes got=%0d want=%0d", wr, NL); end
  endtask

  task automatic test_unload_toggle();
    int lat, wr, rd, hi;
    do_reset();
    run_perm(2, lat, wr, rd, hi);
    total++;
    if (lat !== LAT + NL) begin bad++; $display("FAIL unload_latency got=%0d want=%0d", lat, LAT + NL); end
    total++;
    if (rd !== NL) begin bad++; $display("FAIL unload_beats got=%0d want=%0d", rd, NL); end
  endtask

  task automatic test_random();
    int lat, wr, rd, hi;
    do_reset();
    for (int i = 0; i < 2; i++) begin
      run_perm(3, lat, wr, rd, hi);
      total++;
      if (wr !== NL || rd !== NL) begin bad++; $display("FAIL random_beats wr=%0d rd=%0d want=%0d", wr, rd, NL); end
    end
  endtask

  task automatic test_start_ignored();
    int lat, wr, rd, hi;
    do_reset();
    run_perm(4, lat, wr, rd, hi);
    total++;
    if (lat !== LAT) begin bad++; $display("FAIL start_busy_latency got=%0d want=%0d", lat, LAT); end
  endtask

  task automatic test_reset_mid();
    int lat, wr, rd, hi;
    do_reset();
    run_perm(5, lat, wr, rd, hi);
    total++;
    if (lat !== -2) begin bad++; $display("FAIL mid_reset_reached got=%0d want=-2", lat); end
    run_perm(0, lat, wr, rd, hi);
    total++;
    if (lat !== LAT) begin bad++; $display("FAIL after_reset_latency got=%0d want=%0d", lat, LAT); end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_load_stall();
    test_unload_toggle();
    test_random();
    test_start_ignored();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/perm_round_controller.md
Name: perm_round_controller

Overview:
- Sequencer for the permutation datapath: owns a lane counter and a round counter and steps the datapath through load, per-round transform stages and unload.
- Sits between the top-level start/done interface and the lane-addressed state memory / transform units.
- Provides valid/ready handshakes on the input and output lane streams so upstream and downstream can stall.

Parameters:
- NUM_LANES, 25, lanes per state; lane sweep length.
- LANE_W, 5, lane address width; must satisfy 2^LANE_W >= NUM_LANES.
- NUM_ROUNDS, 24, rounds per permutation.
- ROUND_W, 5, round index width; must satisfy 2^ROUND_W >= NUM_ROUNDS.

Ports:
- clk  in  1  system clock; all state changes on posedge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request a permutation; sampled only in IDLE.
- busy  out  1  high in every state except IDLE.
- in_valid  in  1  input lane available.
- in_ready  out  1  controller accepts an input lane (LOAD only).
- out_valid  out  1  output lane presented (UNLOAD only).
- out_ready  in  1  downstream accepts the output lane.
- lane_addr  out  LANE_W  current lane index into state memory.
- round_idx  out  ROUND_W  current round, 0..NUM_ROUNDS-1.
- stage_sel  out  2  0=THETA, 1=RHO_PI, 2=CHI, 3=IOTA; valid while in a transform state.
- mem_we  out  1  write enable for state memory at lane_addr.
- done  out  1  one-cycle pulse at end of UNLOAD.

Behaviour:
- Reset (asynchronous, active-high): state=IDLE; lane and round counters=0. Outputs: busy=0, in_ready=0, out_valid=0, mem_we=0, done=0, lane_addr=0, round_idx=0, stage_sel=0. Reset mid-operation aborts immediately; no partial done.
- States: IDLE, LOAD, THETA, RHO_PI, CHI, IOTA, UNLOAD, DONE.
- IDLE: start=1 -> LOAD, lane=0, round=0. start is ignored in all other states.
- LOAD: in_ready=1; mem_we=in_valid. Lane increments only on in_valid&in_ready. On the accepted beat with lane==NUM_LANES-1 -> THETA, lane=0.
- THETA, RHO_PI, CHI: one lane per cycle, no stalls, mem_we=1. At lane==NUM_LANES-1: lane=0, advance to the next stage in that order.
- IOTA: single cycle, lane_addr=0, mem_we=1.
  - If round==NUM_ROUNDS-1: -> UNLOAD, round=0.
  - Otherwise: round+1, -> THETA.
- Lane terminal count is the compare lane==NUM_LANES-1, not all-ones; the counter never exceeds NUM_LANES-1.
- UNLOAD: out_valid=1, mem_we=0. Lane advances only on out_valid&out_ready. Last accepted beat (lane==NUM_LANES-1) -> DONE, lane=0.
- DONE: done=1 for exactly one cycle, busy=1 -> IDLE. start in this cycle is ignored.
- round_idx holds constant for the whole round, including IOTA.
- Latency with no stalls, start to done: 1 + NUM_LANES + NUM_ROUNDS*(3*NUM_LANES+1) + NUM_LANES + 1. Defaults: 1+25+1824+25+1 = 1876 cycles.
- Stalls (in_valid=0, out_ready=0) hold the state and lane; there is no timeout.
- All outputs are registered-state decodes. The only input-to-output combinational path is in_valid -> mem_we in LOAD.

Decomposition:
- Shared package: state encoding, stage_sel encodings (STAGE_THETA..STAGE_IOTA), NUM_LANES and NUM_ROUNDS defaults.
- Natural sub-module: the codebase's existing parameterised loadable up-counter, instanced twice (lane, round).
  - Drive loadEn with initCount=0 for wrap/clear.
  - Use the controller's own terminal compares; do not use the counter's all-ones carry.

Test Plan:
- Reset, then start pulse, in_valid=1 and out_ready=1 throughout -> done pulses exactly 1876 cycles after the start cycle. busy=1 from the cycle after start until done inclusive. 25 LOAD writes and 25 UNLOAD beats observed.
- Sequence check -> per round, lane_addr sweeps 0..24 for stage_sel 0, 1, 2, then one IOTA cycle at lane 0. round_idx steps 0..23. No lane_addr value 25..31 ever appears.
- in_valid low for 3 cycles at lane 7 during LOAD -> lane_addr holds 7, mem_we=0 while stalled, resumes at 7. Total latency grows by exactly 3.
- out_ready toggled every other cycle in UNLOAD -> each lane 0..24 presented until accepted. done follows the accept of lane 24 by one cycle.
- start asserted while busy (mid CHI, round 5) and in the DONE cycle -> ignored; no restart, round/lane unaffected.
- rst asserted mid-round 10 -> next edge state is IDLE with all outputs at reset values. A following start runs a full 1876-cycle permutation.
